// File: rtl/complex_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package complex_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } cu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } cu_state_e;

  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN       = 32'h80000000;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/complex_divider.sv
// Iterative restoring divider core: unsigned operands, one quotient bit per cycle.
module complex_divider
  import complex_pkg::*;
(
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_ni,
  input  logic        abort_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  logic        run;
  logic [4:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;

  assign shifted = {rem, quo[31]};
  assign fits    = shifted >= {1'b0, dvs};
  assign diff    = shifted[31:0] - dvs;

  // done_o marks the cycle whose closing edge performs the final iteration
  assign done_o      = run && (cnt == LAST_ITER);
  assign quotient_o  = quo;
  assign remainder_o = rem;

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rst_ni) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (abort_i) begin
      run <= 1'b0;
    end else if (start_i) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 5'd1;
      if (cnt == LAST_ITER) run <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (start_i) begin
      quo <= dividend_i;
      rem <= '0;
      dvs <= divisor_i;
    end else if (run) begin
      if (fits) begin
        rem <= diff;
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= shifted[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/complex_unit.sv
// RV32M multiply/divide execution unit: pipelined MUL/MULH*, iterative DIV/REM*.
// Optional COMPLEX_DIV_EARLY_OUT_EN: divides with |rs1| < |rs2| finish in one cycle.
module complex_unit
  import complex_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_ni,
  input  logic        flush_i,
  input  logic        cu_valid_i,
  input  logic [2:0]  cu_opcode_i,
  input  logic [31:0] cu_operand1_i,
  input  logic [31:0] cu_operand2_i,
  output logic        busy_o,
  output logic [31:0] result_o,
  output logic        wb_valid_o
);

  cu_op_e    op;
  cu_state_e state;
  logic      accept, is_mul;

  assign op     = cu_op_e'(cu_opcode_i);
  assign is_mul = !cu_opcode_i[2];
  assign accept = cu_valid_i && (state == IDLE) && !flush_i;

  // Stage p0: operand extension and product (low 64 bits of the 66-bit product suffice)
  logic signed [32:0] mul_a_p0, mul_b_p0;
  logic signed [63:0] prod_p0;
  logic [31:0]        mul_res_p0, mul_res_p1, mul_res_p2, mul_out;
  logic               vld_p1, vld_p2, mul_last;

  assign mul_a_p0   = {(op != OP_MULHU) & cu_operand1_i[31], cu_operand1_i};
  assign mul_b_p0   = {((op == OP_MUL) || (op == OP_MULH)) & cu_operand2_i[31], cu_operand2_i};
  assign prod_p0    = 64'(mul_a_p0) * 64'(mul_b_p0);
  assign mul_res_p0 = (op == OP_MUL) ? prod_p0[31:0] : prod_p0[63:32];

  // Stage p1/p2: product pipe
  always_ff @(posedge cpu_clk_i) begin
    mul_res_p1 <= mul_res_p0;
    mul_res_p2 <= mul_res_p1;
  end

  assign mul_out  = (MUL_STAGES >= 3) ? mul_res_p2 : (MUL_STAGES == 2) ? mul_res_p1 : mul_res_p0;
  assign mul_last = (MUL_STAGES >= 3) ? vld_p2 : vld_p1;

  logic        div_signed, div_rem, s1, s2, div_zero, div_ovf, fast_hit;
  logic [31:0] abs1, abs2, fast_res, quo, rem, fix_res;
  logic        neg_q_p1, neg_r_p1, rem_sel_p1, div_done;

  assign div_signed = !cu_opcode_i[0];
  assign div_rem    = cu_opcode_i[1];
  assign s1         = div_signed & cu_operand1_i[31];
  assign s2         = div_signed & cu_operand2_i[31];
  assign abs1       = neg_if(s1, cu_operand1_i);
  assign abs2       = neg_if(s2, cu_operand2_i);
  assign div_zero   = (cu_operand2_i == '0);
  assign div_ovf    = div_signed && (cu_operand1_i == INT_MIN) && (cu_operand2_i == '1);

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (div_zero) begin
      fast_hit = 1'b1;
      fast_res = div_rem ? cu_operand1_i : DIV_BY_ZERO_Q;
    end else if (div_ovf) begin
      fast_hit = 1'b1;
      fast_res = div_rem ? '0 : INT_MIN;
    end
`ifdef COMPLEX_DIV_EARLY_OUT_EN
    else if (abs1 < abs2) begin
      fast_hit = 1'b1;
      fast_res = div_rem ? cu_operand1_i : '0;
    end
`else
`endif
  end

  always_ff @(posedge cpu_clk_i) begin
    if (accept) begin
      neg_q_p1   <= s1 ^ s2;
      neg_r_p1   <= s1;
      rem_sel_p1 <= div_rem;
    end
  end

  complex_divider u_div (
    .cpu_clk_i   (cpu_clk_i),
    .cpu_rst_ni  (cpu_rst_ni),
    .abort_i     (flush_i),
    .start_i     (accept && !is_mul && !fast_hit),
    .dividend_i  (abs1),
    .divisor_i   (abs2),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  assign fix_res = rem_sel_p1 ? neg_if(neg_r_p1, rem) : neg_if(neg_q_p1, quo);

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rst_ni) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      wb_valid_o <= 1'b0;
      result_o   <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      vld_p1     <= accept && is_mul;
      vld_p2     <= vld_p1 && !flush_i;
      if (flush_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cu_valid_i) begin
            busy_o <= 1'b1;
            if (is_mul) begin
              if (MUL_STAGES == 1) begin
                state      <= DONE;
                wb_valid_o <= 1'b1;
                result_o   <= mul_res_p0;
              end else begin
                state <= MUL;
              end
            end else if (fast_hit) begin
              state      <= DONE;
              wb_valid_o <= 1'b1;
              result_o   <= fast_res;
            end else begin
              state <= DIV;
            end
          end
          MUL: if (mul_last) begin
            state      <= DONE;
            wb_valid_o <= 1'b1;
            result_o   <= mul_out;
          end
          DIV: if (div_done) state <= FIX;
          FIX: begin
            state      <= DONE;
            wb_valid_o <= 1'b1;
            result_o   <= fix_res;
          end
          DONE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_complex_unit.sv
// Bench for complex_unit: behavioural model plus per-cycle compare and directed vectors.
module tb_complex_unit;

  localparam int MUL_STAGES = 2;
`ifdef COMPLEX_DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 34;
`endif

  logic        cpu_clk_i = 1'b0;
  logic        cpu_rst_ni, flush_i, cu_valid_i;
  logic [2:0]  cu_opcode_i;
  logic [31:0] cu_operand1_i, cu_operand2_i;
  logic        busy_o, wb_valid_o;
  logic [31:0] result_o;

  complex_unit #(.MUL_STAGES(MUL_STAGES)) dut (
    .cpu_clk_i     (cpu_clk_i),
    .cpu_rst_ni    (cpu_rst_ni),
    .flush_i       (flush_i),
    .cu_valid_i    (cu_valid_i),
    .cu_opcode_i   (cu_opcode_i),
    .cu_operand1_i (cu_operand1_i),
    .cu_operand2_i (cu_operand2_i),
    .busy_o        (busy_o),
    .result_o      (result_o),
    .wb_valid_o    (wb_valid_o)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  int          cyc = 0, checks = 0, errors = 0;
  int          m_acc = -1, m_done = -1, m_kill = 1 << 30;
  logic [31:0] m_res = '0;
  bit          model_on = 1'b0;
  int          wb_count = 0, last_wb_cyc = -1;
  logic [31:0] last_res = '0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural result of an RV32M op, straight from the ISA definition
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        ps = sa / sb; return ps[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        ps = sa % sb; return ps[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_STAGES;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef COMPLEX_DIV_EARLY_OUT_EN
    begin
      longint ma, mb;
      ma = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
      mb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (ma < mb) return 1;
    end
`endif
    return 34;
  endfunction

  // Per-cycle compare, 1 time unit after each rising edge
  always @(posedge cpu_clk_i) begin
    if (model_on && cpu_rst_ni && cu_valid_i && busy_o) begin
      errors++;
      $display("FAIL issue_while_busy at cycle %0d", cyc);
    end
    cyc = cyc + 1;
    #1;
    if (model_on) begin
      check32("wb_valid", 32'(wb_valid_o), 32'(cyc == m_done && cyc < m_kill));
      check32("busy", 32'(busy_o), 32'(cyc >= m_acc && cyc <= m_done && cyc < m_kill));
      if (cyc == m_done && cyc < m_kill) check32("result", result_o, m_res);
      if (wb_valid_o === 1'b1) begin
        wb_count++;
        last_res    = result_o;
        last_wb_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int acc);
    @(negedge cpu_clk_i);
    cu_opcode_i   = op;
    cu_operand1_i = a;
    cu_operand2_i = b;
    cu_valid_i    = 1'b1;
    acc    = cyc + 1;
    m_acc  = acc;
    m_done = acc + lat(op, a, b) - 1;
    m_kill = 1 << 30;
    m_res  = model(op, a, b);
    @(negedge cpu_clk_i);
    cu_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o !== 1'b0 && n < 60) begin
      @(negedge cpu_clk_i);
      n++;
    end
    if (n >= 60) begin
      errors++;
      $display("FAIL busy_timeout busy %b after %0d cycles, required 0", busy_o, n);
    end
  endtask

  task automatic op_chk(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int acc;
    last_wb_cyc = -1;
    issue(op, a, b, acc);
    wait_idle();
    check32({nm, "_res"}, last_res, exp_r);
    check32({nm, "_lat"}, 32'(last_wb_cyc - acc + 1), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int acc, base;
    cpu_rst_ni = 1'b0; flush_i = 1'b0; cu_valid_i = 1'b0;
    cu_opcode_i = '0; cu_operand1_i = '0; cu_operand2_i = '0;
    repeat (3) @(negedge cpu_clk_i);
    cpu_rst_ni = 1'b1;
    check32("rst_busy", 32'(busy_o), 32'd0);
    check32("rst_wb", 32'(wb_valid_o), 32'd0);
    check32("rst_result", result_o, 32'd0);
    model_on = 1'b1;

    check32("pin_model_mul", model(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check32("pin_model_rem", model(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    op_chk("mul",     3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    op_chk("mulhu",   3'd3, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 2);
    op_chk("mulh",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2);
    op_chk("mulhsu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    op_chk("mulh_m1", 3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2);
    op_chk("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    op_chk("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    op_chk("div_nd",  3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    op_chk("rem_nd",  3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34);
    op_chk("divu",    3'd5, 32'd100,      32'd7,        32'd14,       34);
    op_chk("remu",    3'd7, 32'd100,      32'd7,        32'd2,        34);
    op_chk("divu_z",  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    op_chk("rem_z",   3'd6, 32'd5,        32'd0,        32'd5,        1);
    op_chk("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    op_chk("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    op_chk("div_eo",  3'd4, 32'd3,        32'd10,       32'd0,        EO_LAT);
    op_chk("rem_eo",  3'd6, 32'd3,        32'd10,       32'd3,        EO_LAT);
    op_chk("rem_eon", 3'd6, 32'hFFFFFFFD, 32'd10,       32'hFFFFFFFD, EO_LAT);

    // Flush mid-divide, then a multiply right behind it
    base = wb_count;
    issue(3'd4, 32'd1000, 32'd3, acc);
    repeat (9) @(negedge cpu_clk_i);
    flush_i = 1'b1;
    m_kill  = cyc + 1;
    @(negedge cpu_clk_i);
    flush_i = 1'b0;
    check32("flush_busy", 32'(busy_o), 32'd0);
    check32("flush_wb", 32'(wb_valid_o), 32'd0);
    last_wb_cyc = -1;
    issue(3'd0, 32'd3, 32'd4, acc);
    wait_idle();
    check32("post_flush_mul", last_res, 32'd12);
    check32("post_flush_lat", 32'(last_wb_cyc - acc + 1), 32'd2);
    repeat (30) @(negedge cpu_clk_i);
    check32("flush_wbcount", 32'(wb_count - base), 32'd1);

    // Flush coincident with issue: nothing accepted
    base = wb_count;
    @(negedge cpu_clk_i);
    cu_opcode_i = 3'd0; cu_operand1_i = 32'd5; cu_operand2_i = 32'd6;
    cu_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge cpu_clk_i);
    cu_valid_i = 1'b0; flush_i = 1'b0;
    repeat (5) @(negedge cpu_clk_i);
    check32("flush_issue_wbcount", 32'(wb_count - base), 32'd0);

    // Reset mid-divide
    base = wb_count;
    issue(3'd4, 32'd1000, 32'd3, acc);
    repeat (5) @(negedge cpu_clk_i);
    cpu_rst_ni = 1'b0;
    m_kill     = cyc + 1;
    @(negedge cpu_clk_i);
    cpu_rst_ni = 1'b1;
    check32("midrst_busy", 32'(busy_o), 32'd0);
    check32("midrst_wb", 32'(wb_valid_o), 32'd0);
    check32("midrst_result", result_o, 32'd0);
    repeat (40) @(negedge cpu_clk_i);
    check32("midrst_wbcount", 32'(wb_count - base), 32'd0);

    op_chk("after_rst", 3'd5, 32'd1000, 32'd3, 32'd333, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_unit.md
Name: complex_unit

Overview:
RV32M multiply/divide execution unit, directly downstream of the memory scheduler's complex-issue path. It accepts one operation per valid pulse and computes MUL/MULH* through a short fixed pipeline, and DIV/REM* through an iterative restoring divider. It returns a single-cycle writeback pulse with the 32-bit result. The scheduler never issues while an operation is outstanding, and it alone tracks the destination and ROB id.

Parameters:
MUL_STAGES, 2, register stages in multiply path; legal 1..3; wb_valid_o rises MUL_STAGES cycles after the accept edge.

Ports:
cpu_clk_i  in  1  core clock; all state updates on rising edge
cpu_rst_ni  in  1  reset, synchronous, active-low
flush_i  in  1  pipeline flush; aborts any in-flight operation
cu_valid_i  in  1  issue strobe, one-cycle pulse
cu_opcode_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
cu_operand1_i  in  32  rs1 value
cu_operand2_i  in  32  rs2 value
busy_o  out  1  operation in flight (state != IDLE)
result_o  out  32  result; valid only while wb_valid_o=1
wb_valid_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (cpu_rst_ni=0 at an edge): state=IDLE, busy_o=0, wb_valid_o=0, result_o=0, mul pipe valids cleared. Reset takes priority over flush and valid.
- Accept: cu_valid_i=1 && state==IDLE && !flush_i. A valid seen while busy is ignored and must be flagged by a bench assertion.
- States:
  - IDLE: waits for accept. MUL ops go to MUL. DIV ops go to DIV, or to DONE on the fast path.
  - MUL: multiply runs for MUL_STAGES cycles, then DONE.
  - DIV: 32 iterations, then FIX.
  - FIX: sign correction, then DONE.
  - DONE: drives wb_valid_o=1 for exactly one cycle, then IDLE.
- Multiply:
  - Operands are extended to 33 bits: signed for MUL/MULH/MULH rs1 of MULHSU; zero-extended for MULHU and rs2 of MULHSU.
  - A 66-bit product is formed. MUL returns [31:0]; the others return [63:32].
  - wb_valid_o is high in cycle N+MUL_STAGES, where N is the accept edge.
- Divide:
  - Signed ops take absolute values and record quotient sign (sign1^sign2) and remainder sign (sign1).
  - Each cycle shifts one quotient bit in, using a 33-bit subtract-and-restore.
  - FIX negates as required.
  - wb_valid_o is high in cycle N+34: 32 iterations + FIX + DONE.
- Divide fast paths, completing at N+1 through DONE:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return operand1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- busy_o rises the cycle after accept and falls the cycle after the wb_valid_o pulse, so the scheduler may reissue on that edge.
- Flush: if flush_i=1 at an edge, state goes to IDLE, mul pipe valids clear, and wb_valid_o=0 next cycle. A completion pending in that same cycle is suppressed. Flush coincident with cu_valid_i: the flush wins and nothing is accepted.
- result_o holds its last value outside the wb pulse; it must not be consumed then.

Optional Feature:
COMPLEX_DIV_EARLY_OUT_EN
- With the macro defined: for divide ops with a nonzero divisor where |operand1| < |operand2| (unsigned compare after abs), complete via DONE at N+1. Quotient=0; remainder=operand1 (original signed value).
- Without the macro: these cases take the full 34-cycle path with an identical result.

Decomposition:
- Package complex_pkg holds:
  - cu_op_e, a 3-bit enum of the eight funct3 codes.
  - cu_state_e: IDLE, MUL, DIV, FIX, DONE.
  - Constants DIV_ITERS=32, DIV_BY_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000.
- One sub-module, complex_divider: an iterative core with start/abs operands in and done/quotient/remainder out, including the counter and restore logic. complex_unit owns sign handling, fast paths, the mul pipe and the FSM.

Test Plan:
- MUL 0x00000007 * 0xFFFFFFFD (MUL_STAGES=2) -> wb_valid_o at N+2, result_o=0xFFFFFFEB; MULHU of the same operands -> 0x00000006.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> result_o 0xFFFFFFFD at N+34; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; busy_o high N+1..N+34.
- DIVU 5 / 0 -> 0xFFFFFFFF at N+1; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Issue DIV 1000 / 3, flush_i at N+10 -> no wb_valid_o within 40 cycles, busy_o=0 at N+11. A new MUL 3 * 4 at N+12 -> 12 at N+14. Repeat with cpu_rst_ni=0 mid-divide -> all outputs 0 next cycle.
- COMPLEX_DIV_EARLY_OUT_EN defined: DIV 3 / 10 -> quotient 0 at N+1 and REM -> 3. Undefined: same results at N+34.
